// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle for one requester of the shared ALU.
// The arbiter sees each requester through the slave modport.
interface alu_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output req_valid, op, a, b, resp_ready,
    input  req_ready, resp_valid
  );

  modport slave (
    input  req_valid, op, a, b, resp_ready,
    output req_ready, resp_valid
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Operands are latched on grant; MUL is held for MUL_CYCLES ALU cycles.
module alu_arbiter #(
  parameter int         DATA_W     = 16,
  parameter int         MUL_CYCLES = 2,
  parameter logic [2:0] OP_MUL     = 3'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      p0,
  alu_arbiter_if.slave      p1,
  output logic [DATA_W-1:0] resp_result,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic              idle;
  logic              win;
  logic              grant;
  logic              own_rdy;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // win selects port 1; on a tie the port that did not go last wins
  assign idle  = (state_q == IDLE);
  assign win   = p1.req_valid & (~p0.req_valid | ~last_q);
  assign grant = idle & (p0.req_valid | p1.req_valid);

  assign p0.req_ready = grant & ~win;
  assign p1.req_ready = grant & win;

  assign w_op = win ? p1.op : p0.op;
  assign w_a  = win ? p1.a  : p0.a;
  assign w_b  = win ? p1.b  : p0.b;

  assign own_rdy = owner_q ? p1.resp_ready : p0.resp_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
    res_d   = res_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          op_d    = w_op;
          a_d     = w_a;
          b_d     = w_b;
          owner_d = win;
          cnt_d   = '0;
          // unknown opcodes fall through as single-cycle
          if (w_op == OP_MUL) cnt_d = MUL_CNT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          rv0_d   = ~owner_q;
          rv1_d   = owner_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (own_rdy) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      res_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      res_q   <= res_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign p0.resp_valid = rv0_q;
  assign p1.resp_valid = rv1_q;
  assign resp_result   = res_q;
  assign alu_op        = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign busy          = ~idle;

endmodule
